// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: round-robin arbiter that lets several cache refill
// requesters share one block memory port. One transaction is in flight at a
// time: IDLE picks a winner, BUSY drives memory from latched values, RESP
// pulses the winner's ready.
// Optional build macro RISCV_ARB_PERF_CNT_EN adds per-port 32-bit grant
// counters on o_riscv_arb_grant_cnt.
module riscv_mem_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 128,
    parameter int S_ADDR     = 10
) (
    input  logic                             i_riscv_clk,
    input  logic                             i_riscv_rst,
    input  logic [NUM_PORTS-1:0]             i_riscv_arb_rden,
    input  logic [NUM_PORTS-1:0]             i_riscv_arb_wren,
    input  logic [NUM_PORTS*S_ADDR-1:0]      i_riscv_arb_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  i_riscv_arb_wdata,
    output logic [NUM_PORTS-1:0]             o_riscv_arb_ready,
    output logic [DATA_WIDTH-1:0]            o_riscv_arb_rdata,
    output logic                             o_riscv_arb_mem_rden,
    output logic                             o_riscv_arb_mem_wren,
    output logic [S_ADDR-1:0]                o_riscv_arb_mem_addr,
    output logic [DATA_WIDTH-1:0]            o_riscv_arb_mem_wdata,
    input  logic [DATA_WIDTH-1:0]            i_riscv_arb_mem_rdata,
    input  logic                             i_riscv_arb_mem_ready
`ifdef RISCV_ARB_PERF_CNT_EN
    ,
    output logic [NUM_PORTS*32-1:0]          o_riscv_arb_grant_cnt
`endif
);

    localparam int PTR_W = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [NUM_PORTS-1:0]   req;
    logic                   any_req;
    logic [PTR_W-1:0]       pick;
    logic [PTR_W-1:0]       grant;
    logic [PTR_W-1:0]       last_grant;
    logic [S_ADDR-1:0]      lat_addr;
    logic [DATA_WIDTH-1:0]  lat_wdata;
    logic                   lat_wr;

    assign req     = i_riscv_arb_rden | i_riscv_arb_wren;
    assign any_req = |req;

    // Round-robin search starting one past the last granted port
    always_comb begin : rr_search
        logic        found;
        int unsigned idx;
        logic [PTR_W-1:0] cand;
        found = 1'b0;
        pick  = last_grant;
        idx   = 0;
        cand  = '0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            idx  = (32'(last_grant) + i) % NUM_PORTS;
            cand = PTR_W'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // State register; reset abandons any in-flight transaction
    always_ff @(posedge i_riscv_clk or posedge i_riscv_rst) begin
        if (i_riscv_rst) state <= IDLE;
        else             state <= state_nxt;
    end

    // Next-state logic; memory ready only matters while BUSY
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BUSY;
            BUSY:    if (i_riscv_arb_mem_ready) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the winner's request and capture read data on completion
    always_ff @(posedge i_riscv_clk or posedge i_riscv_rst) begin
        if (i_riscv_rst) begin
            grant             <= '0;
            last_grant        <= PTR_W'(NUM_PORTS - 1);
            lat_addr          <= '0;
            lat_wdata         <= '0;
            lat_wr            <= 1'b0;
            o_riscv_arb_rdata <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                grant      <= pick;
                last_grant <= pick;
                lat_addr   <= i_riscv_arb_addr[pick*S_ADDR +: S_ADDR];
                lat_wdata  <= i_riscv_arb_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
                // wren wins over rden when a port raises both
                lat_wr     <= i_riscv_arb_wren[pick];
            end
            if (state == BUSY && i_riscv_arb_mem_ready && !lat_wr)
                o_riscv_arb_rdata <= i_riscv_arb_mem_rdata;
        end
    end

    // Outputs: memory side from latched values only, ready pulse in RESP
    always_comb begin
        o_riscv_arb_ready     = '0;
        o_riscv_arb_mem_rden  = (state == BUSY) && !lat_wr;
        o_riscv_arb_mem_wren  = (state == BUSY) && lat_wr;
        o_riscv_arb_mem_addr  = lat_addr;
        o_riscv_arb_mem_wdata = lat_wdata;
        if (state == RESP) o_riscv_arb_ready[grant] = 1'b1;
    end

`ifdef RISCV_ARB_PERF_CNT_EN
    logic [31:0] grant_cnt [NUM_PORTS];

    // Count completed transactions per port, wrapping at 2^32
    always_ff @(posedge i_riscv_clk or posedge i_riscv_rst) begin
        if (i_riscv_rst) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) grant_cnt[i] <= '0;
        end else if (state == RESP) begin
            grant_cnt[grant] <= grant_cnt[grant] + 32'd1;
        end
    end

    // Flatten counters onto the output bus
    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++)
            o_riscv_arb_grant_cnt[i*32 +: 32] = grant_cnt[i];
    end
`endif

endmodule

// File: doc/riscv_mem_arbiter.md
RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 SHALL provide parameter NUM_PORTS, default 2: number of cache refill requesters, legal range 2..8.
REQ-002 SHALL provide parameter DATA_WIDTH, default 128: block width in bits.
REQ-003 SHALL provide parameter S_ADDR, default 10: block address width in bits.
REQ-004 SHALL derive local parameter PTR_W = $clog2(NUM_PORTS).
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 i_riscv_clk  input  1  clock.
REQ-007 i_riscv_rst  input  1  asynchronous active-high reset.
REQ-008 i_riscv_arb_rden  input  NUM_PORTS  per-port block read request.
REQ-009 i_riscv_arb_wren  input  NUM_PORTS  per-port block write request.
REQ-010 i_riscv_arb_addr  input  NUM_PORTS*S_ADDR  per-port block address; port p occupies slice [p*S_ADDR +: S_ADDR].
REQ-011 i_riscv_arb_wdata  input  NUM_PORTS*DATA_WIDTH  per-port write block; port p occupies slice [p*DATA_WIDTH +: DATA_WIDTH].
REQ-012 o_riscv_arb_ready  output  NUM_PORTS  per-port one-cycle completion pulse.
REQ-013 o_riscv_arb_rdata  output  DATA_WIDTH  registered read block, broadcast to all ports.
REQ-014 o_riscv_arb_mem_rden / o_riscv_arb_mem_wren  output  1 each  memory strobes.
REQ-015 o_riscv_arb_mem_addr  output  S_ADDR  memory block address.
REQ-016 o_riscv_arb_mem_wdata  output  DATA_WIDTH  memory write data.
REQ-017 i_riscv_arb_mem_rdata  input  DATA_WIDTH  memory read data.
REQ-018 i_riscv_arb_mem_ready  input  1  memory completion pulse.

Function
REQ-019 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-020 IDLE, when any port has rden or wren set: select the winner round-robin, latch its address, wdata and op, and go to BUSY next cycle.
REQ-021 Round-robin search SHALL start at (last_grant+1) mod NUM_PORTS; last_grant SHALL update on every grant.
REQ-022 A port with both rden and wren set SHALL be treated as a write; rden is ignored for that transaction.
REQ-023 BUSY SHALL drive the memory strobe, address and wdata from latched registers only; later requester input changes have no effect on the memory side.
REQ-024 BUSY with i_riscv_arb_mem_ready=1: for reads, capture i_riscv_arb_mem_rdata into o_riscv_arb_rdata; for writes, leave o_riscv_arb_rdata unchanged; then go to RESP.
REQ-025 RESP SHALL assert o_riscv_arb_ready[grant] for exactly one cycle, hold both memory strobes low, and return to IDLE.
REQ-026 Arbitration latency from IDLE SHALL be 1 cycle to memory strobe; total = 1 + memory latency + 1 cycles.
REQ-027 At most one o_riscv_arb_ready bit SHALL be set in any cycle; mem_rden and mem_wren SHALL never both be set.
REQ-028 i_riscv_arb_mem_ready SHALL be ignored outside BUSY.
REQ-029 Requests from non-granted ports SHALL stay pending, not dropped; a requester SHALL hold its request until its ready pulse.
REQ-030 Each of N continuously requesting ports SHALL be granted within N transactions.

Reset
REQ-031 Reset SHALL force IDLE immediately, even mid-transaction; any in-flight transaction is abandoned with no ready pulse.
REQ-032 Reset values: o_riscv_arb_ready=0, mem strobes=0, mem_addr=0, mem_wdata=0, o_riscv_arb_rdata=0, last_grant=NUM_PORTS-1 (port 0 wins first).

Configuration
REQ-033 Macro RISCV_ARB_PERF_CNT_EN defined: add output o_riscv_arb_grant_cnt, width NUM_PORTS*32; port p's 32-bit counter increments on each of its RESP cycles, wraps modulo 2^32, and resets to 0.
REQ-034 Macro undefined: the port and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-035 NUM_PORTS=2, port0 read addr 0x05, memory returns 0xA5..A5 after 3 cycles -> mem_rden high 3 cycles, rdata=0xA5..A5, ready[0] pulses once, total 5 cycles.
REQ-036 Ports 0 and 1 request in the same cycle from reset -> port0 served first, then port1; ready pulses ordered 0 then 1.
REQ-037 NUM_PORTS=4, all ports request continuously -> grant order 0,1,2,3,0, with no port starved.
REQ-038 Port1 sets rden and wren together with wdata=0x1234 -> only mem_wren asserts, mem_wdata=0x1234, rdata unchanged.
REQ-039 Reset asserted in BUSY -> strobes drop in the same cycle, no ready pulse, and the next request is granted to port 0.
REQ-040 RISCV_ARB_PERF_CNT_EN defined, 3 transactions on port 2 -> grant_cnt slice 2 = 3, other slices = 0.
